// File: rtl/dram_cmd_pkg.sv
// Shared types and default widths for the DRAM command frontend.
package dram_cmd_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;
    localparam int TAG_W_DEF  = 4;
    localparam int DEPTH_DEF  = 8;

    // One host command as held in the queue (default widths).
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [TAG_W_DEF-1:0]  tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } fe_state_e;

    // Queue pointers carry one extra wrap bit to tell full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dram_cmd_queue.sv
// In-order command FIFO with a parallel address compare against queued
// writes. The head is read combinationally so the scheduler sees it the
// same cycle it lands; the compare returns the newest matching write.
module dram_cmd_queue
    import dram_cmd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              push_we,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_wdata,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic              pop,
    output logic              empty,
    output logic              full,
    output logic              head_we,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_wdata,
    output logic [TAG_W-1:0]  head_tag,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_wdata
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     count;
    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     slot;
    logic [DEPTH-1:0]  match;

    logic              we_mem    [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [DATA_W-1:0] wdata_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem   [DEPTH];

    assign rd_idx = rd_ptr_reg[AW-1:0];
    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign count  = wr_ptr_reg - rd_ptr_reg;
    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);

    // Pointer advance; reset discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            we_mem[wr_idx]    <= push_we;
            addr_mem[wr_idx]  <= push_addr;
            wdata_mem[wr_idx] <= push_wdata;
            tag_mem[wr_idx]   <= push_tag;
        end
    end

    // Head fields are forced to zero when nothing is queued.
    assign head_we    = empty ? 1'b0 : we_mem[rd_idx];
    assign head_addr  = empty ? '0   : addr_mem[rd_idx];
    assign head_wdata = empty ? '0   : wdata_mem[rd_idx];
    assign head_tag   = empty ? '0   : tag_mem[rd_idx];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi] = we_mem[gi] && (addr_mem[gi] == lookup_addr);
        end
    endgenerate

    // Walk slots oldest to newest so the last live match wins.
    always_comb begin
        hit       = 1'b0;
        hit_wdata = '0;
        slot      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_idx + AW'(k);
            if ((PW'(k) < count) && match[slot]) begin
                hit       = 1'b1;
                hit_wdata = wdata_mem[slot];
            end
        end
    end

endmodule

// File: rtl/dram_cmd_frontend.sv
// Host command receiver: queues commands for the bank scheduler, forwards
// read-after-write hits from queued writes, and merges those forwards with
// backend read data into a single tagged response stream.
// Build option: define CMD_STATS_EN to add saturating write/read/forward
// counters on o_wr_cnt, o_rd_cnt and o_raw_cnt.
module dram_cmd_frontend
    import dram_cmd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    input  logic [TAG_W-1:0]  i_cmd_tag,
    output logic              o_iss_valid,
    input  logic              i_iss_ready,
    output logic              o_iss_we,
    output logic [ADDR_W-1:0] o_iss_addr,
    output logic [DATA_W-1:0] o_iss_wdata,
    output logic [TAG_W-1:0]  o_iss_tag,
    input  logic              i_be_rvalid,
    input  logic [DATA_W-1:0] i_be_rdata,
    input  logic [TAG_W-1:0]  i_be_rtag,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [TAG_W-1:0]  o_rsp_tag,
    input  logic              i_flush,
    output logic              o_flush_done
`ifdef CMD_STATS_EN
    ,
    output logic [31:0]       o_wr_cnt,
    output logic [31:0]       o_rd_cnt,
    output logic [31:0]       o_raw_cnt
`endif
);

    fe_state_e         state_reg;
    fe_state_e         state_next;

    logic              q_empty;
    logic              q_full;
    logic              hit;
    logic [DATA_W-1:0] hit_wdata;
    logic              accept;
    logic              raw_hit;
    logic              push;
    logic              pop;

    logic              hold_full_reg;
    logic [DATA_W-1:0] hold_data_reg;
    logic [TAG_W-1:0]  hold_tag_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic [TAG_W-1:0]  rsp_tag_reg;

    // A read that hits a queued write is answered here and never enqueued.
    assign accept  = i_cmd_valid && o_cmd_ready;
    assign raw_hit = accept && !i_cmd_we && hit;
    assign push    = accept && !raw_hit;
    assign pop     = o_iss_valid && i_iss_ready;

    assign o_iss_valid = !q_empty;

    dram_cmd_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .push        (push),
        .push_we     (i_cmd_we),
        .push_addr   (i_cmd_addr),
        .push_wdata  (i_cmd_wdata),
        .push_tag    (i_cmd_tag),
        .pop         (pop),
        .empty       (q_empty),
        .full        (q_full),
        .head_we     (o_iss_we),
        .head_addr   (o_iss_addr),
        .head_wdata  (o_iss_wdata),
        .head_tag    (o_iss_tag),
        .lookup_addr (i_cmd_addr),
        .hit         (hit),
        .hit_wdata   (hit_wdata)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next state plus ready/done, decoded only from flops so ready never
    // depends combinationally on i_cmd_valid.
    always_comb begin
        state_next   = state_reg;
        o_cmd_ready  = 1'b0;
        o_flush_done = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = ACTIVE;
            end
            ACTIVE: begin
                o_cmd_ready = !q_full && !hold_full_reg;
                if (i_flush) state_next = DRAIN;
            end
            DRAIN: begin
                if (q_empty && !hold_full_reg) begin
                    state_next   = ACTIVE;
                    o_flush_done = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Response mux: backend data wins; a colliding forward parks in the
    // hold register and goes out on the next backend-free cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_tag_reg   <= '0;
            hold_full_reg <= 1'b0;
            hold_data_reg <= '0;
            hold_tag_reg  <= '0;
        end else if (i_be_rvalid) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= i_be_rdata;
            rsp_tag_reg   <= i_be_rtag;
            if (raw_hit) begin
                hold_full_reg <= 1'b1;
                hold_data_reg <= hit_wdata;
                hold_tag_reg  <= i_cmd_tag;
            end
        end else if (hold_full_reg) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= hold_data_reg;
            rsp_tag_reg   <= hold_tag_reg;
            hold_full_reg <= 1'b0;
        end else if (raw_hit) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= hit_wdata;
            rsp_tag_reg   <= i_cmd_tag;
        end else begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_data  = rsp_data_reg;
    assign o_rsp_tag   = rsp_tag_reg;

`ifdef CMD_STATS_EN
    logic [31:0] wr_cnt_reg;
    logic [31:0] rd_cnt_reg;
    logic [31:0] raw_cnt_reg;

    // Saturating event counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
            raw_cnt_reg <= '0;
        end else begin
            if (accept && i_cmd_we && (wr_cnt_reg != 32'hFFFF_FFFF))
                wr_cnt_reg <= wr_cnt_reg + 32'd1;
            if (accept && !i_cmd_we && (rd_cnt_reg != 32'hFFFF_FFFF))
                rd_cnt_reg <= rd_cnt_reg + 32'd1;
            if (raw_hit && (raw_cnt_reg != 32'hFFFF_FFFF))
                raw_cnt_reg <= raw_cnt_reg + 32'd1;
        end
    end

    assign o_wr_cnt  = wr_cnt_reg;
    assign o_rd_cnt  = rd_cnt_reg;
    assign o_raw_cnt = raw_cnt_reg;
`endif

endmodule

// File: tb/tb_dram_cmd_frontend.sv
// Bench for dram_cmd_frontend: queue/forward/response model plus directed
// scenarios with literal expectations.
module tb_dram_cmd_frontend;
    import dram_cmd_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_we = 1'b0;
    logic [31:0] i_cmd_addr = '0;
    logic [63:0] i_cmd_wdata = '0;
    logic [3:0]  i_cmd_tag = '0;
    logic        o_iss_valid;
    logic        i_iss_ready = 1'b0;
    logic        o_iss_we;
    logic [31:0] o_iss_addr;
    logic [63:0] o_iss_wdata;
    logic [3:0]  o_iss_tag;
    logic        i_be_rvalid = 1'b0;
    logic [63:0] i_be_rdata = '0;
    logic [3:0]  i_be_rtag = '0;
    logic        o_rsp_valid;
    logic [63:0] o_rsp_data;
    logic [3:0]  o_rsp_tag;
    logic        i_flush = 1'b0;
    logic        o_flush_done;
`ifdef CMD_STATS_EN
    logic [31:0] o_wr_cnt;
    logic [31:0] o_rd_cnt;
    logic [31:0] o_raw_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dram_cmd_frontend dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_we     (i_cmd_we),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_wdata  (i_cmd_wdata),
        .i_cmd_tag    (i_cmd_tag),
        .o_iss_valid  (o_iss_valid),
        .i_iss_ready  (i_iss_ready),
        .o_iss_we     (o_iss_we),
        .o_iss_addr   (o_iss_addr),
        .o_iss_wdata  (o_iss_wdata),
        .o_iss_tag    (o_iss_tag),
        .i_be_rvalid  (i_be_rvalid),
        .i_be_rdata   (i_be_rdata),
        .i_be_rtag    (i_be_rtag),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_tag    (o_rsp_tag),
        .i_flush      (i_flush),
        .o_flush_done (o_flush_done)
`ifdef CMD_STATS_EN
        ,
        .o_wr_cnt     (o_wr_cnt),
        .o_rd_cnt     (o_rd_cnt),
        .o_raw_cnt    (o_raw_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    cmd_t        mq[$];
    bit          m_started = 0;
    bit          m_drain   = 0;
    bit          m_hold_v  = 0;
    logic [63:0] m_hold_d  = '0;
    logic [3:0]  m_hold_t  = '0;
    bit          m_rsp_v   = 0;
    logic [63:0] m_rsp_d   = '0;
    logic [3:0]  m_rsp_t   = '0;

    function automatic bit m_ready();
        return m_started && !m_drain && (mq.size() < DEPTH) && !m_hold_v;
    endfunction

    task automatic model_step();
        bit          acc;
        bit          popm;
        bit          raw;
        bit          hold_was;
        logic [63:0] fd;
        cmd_t        c;
        acc      = i_cmd_valid && m_ready();
        popm     = (mq.size() != 0) && i_iss_ready;
        hold_was = m_hold_v;
        raw      = 0;
        fd       = '0;
        if (acc && !i_cmd_we) begin
            foreach (mq[k]) begin
                if (mq[k].we && mq[k].addr == i_cmd_addr) begin
                    raw = 1;
                    fd  = mq[k].wdata;
                end
            end
        end
        if (i_be_rvalid) begin
            m_rsp_v = 1; m_rsp_d = i_be_rdata; m_rsp_t = i_be_rtag;
            if (raw) begin
                m_hold_v = 1; m_hold_d = fd; m_hold_t = i_cmd_tag;
            end
        end else if (m_hold_v) begin
            m_rsp_v = 1; m_rsp_d = m_hold_d; m_rsp_t = m_hold_t;
            m_hold_v = 0;
        end else if (raw) begin
            m_rsp_v = 1; m_rsp_d = fd; m_rsp_t = i_cmd_tag;
        end else begin
            m_rsp_v = 0;
        end
        if (m_drain) begin
            if (mq.size() == 0 && !hold_was) m_drain = 0;
        end else if (m_started && i_flush) begin
            m_drain = 1;
        end
        m_started = 1;
        if (popm) void'(mq.pop_front());
        if (acc && !raw) begin
            c.we = i_cmd_we; c.addr = i_cmd_addr; c.wdata = i_cmd_wdata; c.tag = i_cmd_tag;
            mq.push_back(c);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_started = 0; m_drain = 0; m_hold_v = 0; m_rsp_v = 0;
            end else begin
                model_step();
            end
        end
    end

    // Compare process: every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_cmd_ready", o_cmd_ready, 0);
                chk("rst_iss_valid", o_iss_valid, 0);
                chk("rst_rsp_valid", o_rsp_valid, 0);
                chk("rst_flush_done", o_flush_done, 0);
            end else begin
                chk("cmd_ready", o_cmd_ready, m_ready());
                chk("iss_valid", o_iss_valid, mq.size() != 0);
                if (mq.size() != 0) begin
                    chk("iss_we", o_iss_we, mq[0].we);
                    chk("iss_addr", o_iss_addr, mq[0].addr);
                    chk("iss_wdata", o_iss_wdata, mq[0].wdata);
                    chk("iss_tag", o_iss_tag, mq[0].tag);
                end
                chk("rsp_valid", o_rsp_valid, m_rsp_v);
                if (m_rsp_v) begin
                    chk("rsp_data", o_rsp_data, m_rsp_d);
                    chk("rsp_tag", o_rsp_tag, m_rsp_t);
                end
                chk("flush_done", o_flush_done, m_drain && mq.size() == 0 && !m_hold_v);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic we, input logic [31:0] addr, input logic [63:0] data, input logic [3:0] tag);
        i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_addr = addr; i_cmd_wdata = data; i_cmd_tag = tag;
        tick();
        i_cmd_valid = 1'b0;
        $display("cmd we=%0d addr=0x%0h data=0x%0h tag=%0d", we, addr, data, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  issues;
        bit  seen;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_ready", o_cmd_ready, 0);
        chk("reset_iss_valid", o_iss_valid, 0);
        chk("reset_rsp_data", o_rsp_data, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", o_cmd_ready, 1);

        // Write then RAW read of the same address.
        put(1'b1, 32'h40, 64'hAA, 4'd1);
        chk("wr_iss_valid", o_iss_valid, 1);
        chk("wr_iss_addr", o_iss_addr, 32'h40);
        chk("wr_iss_tag", o_iss_tag, 1);
        put(1'b0, 32'h40, 64'h0, 4'd2);
        chk("raw_rsp_valid", o_rsp_valid, 1);
        chk("raw_rsp_data", o_rsp_data, 64'hAA);
        chk("raw_rsp_tag", o_rsp_tag, 2);
        chk("raw_not_queued", o_iss_addr, 32'h40);
`ifdef CMD_STATS_EN
        chk("raw_cnt", o_raw_cnt, 1);
`endif
        i_iss_ready = 1'b1; tick(); i_iss_ready = 1'b0;
        chk("queue_empty", o_iss_valid, 0);

        // Fill to capacity, then a refused command.
        for (int i = 0; i < 8; i++) put(1'b1, 32'h100 + 32'(i * 8), 64'h1000 + 64'(i), 4'(i));
        chk("full_ready_low", o_cmd_ready, 0);
        put(1'b1, 32'h300, 64'h9, 4'd9);
        chk("full_head", o_iss_addr, 32'h100);
        i_iss_ready = 1'b1; tick(); i_iss_ready = 1'b0;
        chk("pop_ready_back", o_cmd_ready, 1);
        chk("pop_new_head", o_iss_addr, 32'h108);

        // Simultaneous push/pop across pointer wrap, with some RAW reads.
        i_iss_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            put((i % 3) != 2, 32'h200 + 32'((i % 4) * 8), 64'h2000 + 64'(i), 4'(i));
        repeat (10) tick();
        i_iss_ready = 1'b0;
        chk("wrap_drained", o_iss_valid, 0);

        // Forward colliding with backend data.
        put(1'b1, 32'h80, 64'h77, 4'd6);
        i_be_rvalid = 1'b1; i_be_rdata = 64'h55; i_be_rtag = 4'd5;
        put(1'b0, 32'h80, 64'h0, 4'd7);
        i_be_rvalid = 1'b0;
        chk("coll_first_tag", o_rsp_tag, 5);
        chk("coll_first_data", o_rsp_data, 64'h55);
        chk("coll_ready_low", o_cmd_ready, 0);
        tick();
        chk("coll_second_valid", o_rsp_valid, 1);
        chk("coll_second_tag", o_rsp_tag, 7);
        chk("coll_second_data", o_rsp_data, 64'h77);
        chk("coll_ready_back", o_cmd_ready, 1);

        // Flush with three queued commands.
        put(1'b1, 32'h90, 64'h90, 4'd8);
        put(1'b1, 32'hA0, 64'hA0, 4'd9);
        i_flush = 1'b1; i_iss_ready = 1'b1;
        issues = 0; seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (o_iss_valid) issues++;
            if (o_flush_done) seen = 1;
            tick();
            if (n == 0) begin
                i_flush = 1'b0;
                chk("drain_ready_low", o_cmd_ready, 0);
            end
        end
        i_iss_ready = 1'b0;
        chk("flush_done_seen", seen, 1);
        chk("flush_issue_count", issues, 3);
        chk("flush_ready_back", o_cmd_ready, 1);
        chk("flush_done_pulse", o_flush_done, 0);
        $display("flush issues=%0d done=%0d", issues, seen);

        // Flush with an empty queue.
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        chk("eflush_done", o_flush_done, 1);
        chk("eflush_ready_low", o_cmd_ready, 0);
        tick();
        chk("eflush_done_off", o_flush_done, 0);
        chk("eflush_ready", o_cmd_ready, 1);

        // Asynchronous reset with four queued and a response pending.
        for (int i = 0; i < 3; i++) put(1'b1, 32'h400 + 32'(i * 8), 64'h40 + 64'(i), 4'(i));
        i_be_rvalid = 1'b1; i_be_rdata = 64'h99; i_be_rtag = 4'd3;
        put(1'b1, 32'h418, 64'h43, 4'd3);
        i_be_rvalid = 1'b0;
        chk("pre_rst_rsp_valid", o_rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", o_cmd_ready, 0);
        chk("arst_iss_valid", o_iss_valid, 0);
        chk("arst_iss_addr", o_iss_addr, 0);
        chk("arst_iss_tag", o_iss_tag, 0);
        chk("arst_iss_wdata", o_iss_wdata, 0);
        chk("arst_rsp_valid", o_rsp_valid, 0);
        chk("arst_rsp_data", o_rsp_data, 0);
        chk("arst_rsp_tag", o_rsp_tag, 0);
        chk("arst_flush_done", o_flush_done, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_iss_valid", o_iss_valid, 0);
        chk("post_rst_ready", o_cmd_ready, 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_cmd_frontend.md
Name: dram_cmd_frontend

Overview:
- Controller-side receiver for the host read/write command stream issued by the DRAM global controller testbench/host.
- Accepts tagged commands over a valid/ready handshake and buffers them in an in-order queue.
- Issues queued commands to the bank scheduler.
- Forwards read-after-write (RAW) hits from queued writes, so those reads never reach the backend.
- Returns all read data tagged; responses may be out of order.

Parameters:
- ADDR_W, 32, command address width.
- DATA_W, 64, write/read data width.
- TAG_W, 4, host command tag width.
- DEPTH, 8, queue entries (power of 2, at least 2).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  host command valid.
- o_cmd_ready  out  1  frontend can accept a command.
- i_cmd_we  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_W  command address.
- i_cmd_wdata  in  DATA_W  write data.
- i_cmd_tag  in  TAG_W  host tag.
- o_iss_valid  out  1  queue head valid toward scheduler.
- i_iss_ready  in  1  scheduler accepts head.
- o_iss_we / o_iss_addr / o_iss_wdata / o_iss_tag  out  1/ADDR_W/DATA_W/TAG_W  head entry fields.
- i_be_rvalid  in  1  backend read data valid (no backpressure).
- i_be_rdata / i_be_rtag  in  DATA_W/TAG_W  backend read data and tag.
- o_rsp_valid  out  1  read response valid (host always accepts).
- o_rsp_data / o_rsp_tag  out  DATA_W/TAG_W  response data and tag.
- i_flush  in  1  request drain.
- o_flush_done  out  1  one-cycle pulse when drain completes.

Behaviour:
- Reset (async, i_rst_n=0): queue empty, state IDLE.
  - All outputs 0: o_cmd_ready, o_iss_valid, o_rsp_valid, o_flush_done, data, tag.
  - Hold register empty.
  - Reset mid-operation discards all queued commands and pending responses.
- Accept: a command is accepted when i_cmd_valid && o_cmd_ready; the handshake is sampled on the rising clock edge.
- o_cmd_ready = (state==ACTIVE) && !full && !hold_full.
  - Registered, derived from registered state only.
  - Has no combinational path from i_cmd_valid.
- Write accept: pushed into the queue.
- Read accept, no RAW hit: pushed into the queue.
- Read accept, RAW hit (address equals any valid queued write, including the head being issued that cycle):
  - Read is not enqueued.
  - Data comes from the newest matching write.
  - Response is produced one cycle later.
- Issue: o_iss_* shows the queue head combinationally from storage. Head is popped on o_iss_valid && i_iss_ready.
- Simultaneous push and pop when full: not possible because ready is low when full. When not full, push and pop in the same cycle keep the count unchanged.
- Response mux:
  - Registered, 1-cycle latency from i_be_rvalid or from the forward.
  - Backend data has priority.
  - A forward colliding with backend data goes into a 1-entry hold register and is emitted on the next cycle with no backend data.
  - While the hold register is full, o_cmd_ready=0.
- FSM:
  - IDLE -> ACTIVE on the first cycle after reset release.
  - ACTIVE -> DRAIN when i_flush=1.
  - DRAIN: o_cmd_ready=0; issuing continues.
  - DRAIN -> ACTIVE when the queue and hold register are empty. o_flush_done pulses in that transition cycle.
  - i_flush while already in DRAIN is ignored.
  - i_flush with an empty queue: DRAIN lasts 1 cycle, then done.
- Pointers: log2(DEPTH)+1 bits wide, wrap modulo 2·DEPTH.
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.

Optional Feature:
- Macro CMD_STATS_EN.
- When defined, adds outputs o_wr_cnt, o_rd_cnt, o_raw_cnt (32 bits each).
  - They count accepted writes, accepted reads, and RAW forwards.
  - Saturating, reset to 0.
- When undefined, these ports and counters are absent. Functional behaviour is identical either way.

Decomposition:
- Package dram_cmd_pkg holds:
  - cmd_t struct (we, addr, wdata, tag).
  - fe_state_e enum {IDLE, ACTIVE, DRAIN}.
  - Default width localparams.
- One sub-module, dram_cmd_queue: the FIFO storage plus a parallel address-compare that returns hit and newest-match data.

Test Plan:
- Write tag 1 addr 0x40 data 0xAA, i_iss_ready=0 -> entry queued, o_iss_valid=1, o_iss_addr=0x40.
- Then read tag 2 addr 0x40 -> o_rsp_valid one cycle later, data 0xAA, tag 2. Issue queue count unchanged; o_raw_cnt=1 with CMD_STATS_EN.
- Fill 8 commands with i_iss_ready=0 -> o_cmd_ready=0 after the 8th. Pop one -> ready reasserts the next cycle; pointer wrap verified after 20 pushes/pops.
- RAW forward in the same cycle as i_be_rvalid (tag 5, data 0x55) -> tag 5 response first, forward one cycle later; o_cmd_ready low for one cycle.
- i_flush with 3 queued and i_iss_ready=1 -> o_cmd_ready=0, 3 issues, then o_flush_done pulse, then back to ACTIVE.
- Assert i_rst_n=0 with 4 queued -> all outputs 0 asynchronously. After release, o_iss_valid=0 and o_cmd_ready=1 by the second cycle.
